// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage data-memory controller: splits each 32-bit load/store into two
// 16-bit accesses to an asynchronous SRAM and freezes the pipeline meanwhile.
module mem_stage_sram_ctrl #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [31:0] BASE = 32'(ADDR_BASE);
  localparam logic [3:0]  LAST = 4'(WAIT_CYCLES - 1);

  state_t             state_q;
  logic [3:0]         cnt_q;
  logic               wr_op_q;
  logic [15:0]        hi_data_q;
  logic [31:0]        read_data_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic               we_n_q;
  logic               oe_n_q;
  logic               dq_oe_q;
  logic [15:0]        dq_out_q;

  logic [31:0] offset;
  logic        last_cycle;
  logic        unused_offset_bits;

  // Halfword address is the byte offset shifted right by one with bit 0 cleared.
  assign offset             = address - BASE;
  assign last_cycle         = (cnt_q == LAST);
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_op_q     <= 1'b0;
      hi_data_q   <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_en || rd_en) begin
            state_q     <= LOW;
            cnt_q       <= '0;
            wr_op_q     <= wr_en;
            hi_data_q   <= write_data[31:16];
            sram_addr_q <= {offset[SRAM_AW:2], 1'b0};
            we_n_q      <= !wr_en;
            oe_n_q      <= wr_en;
            dq_oe_q     <= wr_en;
            dq_out_q    <= wr_en ? write_data[15:0] : 16'h0000;
          end
        end
        LOW: begin
          if (last_cycle) begin
            if (!wr_op_q) read_data_q[15:0] <= sram_dq_in;
            state_q        <= HIGH;
            cnt_q          <= '0;
            sram_addr_q[0] <= 1'b1;
            dq_out_q       <= wr_op_q ? hi_data_q : 16'h0000;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        HIGH: begin
          if (last_cycle) begin
            if (!wr_op_q) read_data_q[31:16] <= sram_dq_in;
            state_q  <= DONE;
            cnt_q    <= '0;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
            dq_out_q <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;  // DONE: requests still held are ignored
      endcase
    end
  end

  assign ready       = (state_q == IDLE && !rd_en && !wr_en) || (state_q == DONE);
  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a small behavioural SRAM model.
module tb_mem_stage_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:63];

  mem_stage_sram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset reloads the two words the first load expects.
  always @(posedge clk) begin
    if (rst) begin
      mem[4] <= 16'h1234;
      mem[5] <= 16'hABCD;
    end else if (!sram_we_n && sram_dq_oe) begin
      mem[sram_addr[5:0]] <= sram_dq_out;
    end
  end

  assign sram_dq_in = !sram_oe_n ? mem[sram_addr[5:0]] : 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full access with WAIT_CYCLES=2: cycle 0 IDLE, 1-2 LOW, 3-4 HIGH, 5 DONE.
  // Requests stay asserted through DONE, as a frozen pipeline would hold them.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [17:0] exp_lo, input logic [31:0] exp_rd);
    @(negedge clk);
    rd_en = rd; wr_en = wr; address = addr; write_data = wdata;
    #1;
    check({tag, " c0 ready"}, 32'(ready), 32'd0);
    check({tag, " c0 we_n"}, 32'(sram_we_n), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      check($sformatf("%s c%0d ready", tag, c), 32'(ready), 32'd0);
      check($sformatf("%s c%0d addr", tag, c), 32'(sram_addr),
            32'(exp_lo) + ((c > 2) ? 32'd1 : 32'd0));
      if (wr) begin
        check($sformatf("%s c%0d we_n", tag, c), 32'(sram_we_n), 32'd0);
        check($sformatf("%s c%0d oe_n", tag, c), 32'(sram_oe_n), 32'd1);
        check($sformatf("%s c%0d dq_oe", tag, c), 32'(sram_dq_oe), 32'd1);
        check($sformatf("%s c%0d dq_out", tag, c), 32'(sram_dq_out),
              (c > 2) ? 32'(wdata[31:16]) : 32'(wdata[15:0]));
      end else begin
        check($sformatf("%s c%0d we_n", tag, c), 32'(sram_we_n), 32'd1);
        check($sformatf("%s c%0d oe_n", tag, c), 32'(sram_oe_n), 32'd0);
        check($sformatf("%s c%0d dq_oe", tag, c), 32'(sram_dq_oe), 32'd0);
        if (c == 3) check({tag, " mid low half"}, 32'(read_data[15:0]), 32'(exp_rd[15:0]));
      end
    end
    @(negedge clk); #1;
    check({tag, " c5 ready"}, 32'(ready), 32'd1);
    check({tag, " c5 strobes"}, {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'd6);
    check({tag, " c5 read_data"}, read_data, exp_rd);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    #1;
    check({tag, " idle ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset read_data", read_data, 32'd0);
    check("reset sram_addr", 32'(sram_addr), 32'd0);
    check("reset strobes", {29'd0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'd6);
    check("reset dq_out", 32'(sram_dq_out), 32'd0);
    check("reset ready", 32'(ready), 32'd1);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check($sformatf("idle%0d", i), {28'd0, ready, sram_we_n, sram_oe_n, sram_dq_oe}, 32'he);
    end

    access("load", 1'b1, 1'b0, 32'd1032, 32'h0, 18'd4, 32'hABCD1234);
    idle_cycle("after load");

    access("store", 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4, 32'hABCD1234);
    idle_cycle("after store");
    check("store mem lo", 32'(mem[4]), 32'h0000BEEF);
    check("store mem hi", 32'(mem[5]), 32'h0000DEAD);

    // Back-to-back: the load's cycle 0 is the IDLE cycle that follows DONE.
    access("b2b store", 1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 18'd8, 32'hABCD1234);
    access("b2b load", 1'b1, 1'b0, 32'd1040, 32'h0, 18'd8, 32'hCAFEF00D);
    idle_cycle("after b2b");

    access("both", 1'b1, 1'b1, 32'd1048, 32'h13572468, 18'd12, 32'hCAFEF00D);
    idle_cycle("after both");
    check("both mem lo", 32'(mem[12]), 32'h00002468);
    check("both mem hi", 32'(mem[13]), 32'h00001357);

    // Address below the base wraps: offset 0xFFFFFC00 -> halfword 0x3FE00.
    access("wrap", 1'b0, 1'b1, 32'd0, 32'h00010002, 18'h3FE00, 32'hCAFEF00D);
    idle_cycle("after wrap");

    // Reset during the second LOW cycle of a store.
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1056; write_data = 32'h55AA55AA;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    #1;
    check("abort we_n", 32'(sram_we_n), 32'd1);
    check("abort oe_n", 32'(sram_oe_n), 32'd1);
    check("abort dq_oe", 32'(sram_dq_oe), 32'd0);
    check("abort ready", 32'(ready), 32'd1);
    check("abort read_data", read_data, 32'd0);

    // Low address bits are ignored: 1043 maps to the same word as 1040.
    access("post-reset load", 1'b1, 1'b0, 32'd1043, 32'h0, 18'd8, 32'hCAFEF00D);
    idle_cycle("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
